// File: rtl/pipe_stage_reg_pkg.sv
// Shared slot-state encoding and sizing helpers for the pipeline stage register.
package pipe_pkg;

  // Per-slot occupancy state. BUSY holds one entry in main; FULL adds one in skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } slot_state_t;

  // Width needed to count every live entry of a chain (up to two per slot).
  function automatic int occ_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

  // Number of live entries represented by a slot state.
  function automatic logic [1:0] slot_occ(input slot_state_t st);
    case (st)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle between pipeline stages.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  // Producer side drives valid/data and observes ready.
  modport master (output valid, output data, input ready);
  // Consumer side observes valid/data and drives ready.
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One pipeline slot: single-entry register or 2-entry skid buffer.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | nothing held, out_valid low
// ST_BUSY  | one entry in main, presented on out_data
// ST_FULL  | main presented, next entry parked in skid
//            (only reachable with SKID=1)
module pipe_stage_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int SKID           = 0,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  slot_state_t       state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  // Skid slots decode ready from state only, breaking the stall path; plain slots pass it through.
  always_comb begin
    if (SKID != 0) begin
      in_ready = (state != ST_FULL);
    end else begin
      in_ready = (state == ST_EMPTY) || out_ready;
    end
  end

  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occ       = slot_occ(state);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Slot FSM: reset beats flush, flush beats any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state  <= ST_BUSY;
            main_q <= in_data;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            // Only possible with SKID=1; plain slots never accept while stalled.
            state  <= ST_FULL;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state  <= ST_BUSY;
            main_q <= skid_q;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: STAGES slots chained valid/ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int STAGES         = 1,
  parameter int SKID           = 0,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  pipe_stage_reg_if.slave            up,
  pipe_stage_reg_if.master           dn,
  output logic [occ_w(STAGES)-1:0]   count
);

  localparam int CW = occ_w(STAGES);

  // Element g is the link feeding slot g; element STAGES is the downstream port.
  logic              link_valid [STAGES+1];
  logic              link_ready [STAGES+1];
  logic [DATA_W-1:0] link_data  [STAGES+1];
  logic [1:0]        slot_occ_w [STAGES];
  logic [CW-1:0]     count_sum;

  assign link_valid[0]      = up.valid;
  assign link_data[0]       = up.data;
  assign up.ready           = link_ready[0];
  assign dn.valid           = link_valid[STAGES];
  assign dn.data            = link_data[STAGES];
  assign link_ready[STAGES] = dn.ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    pipe_stage_slot #(
      .DATA_W        (DATA_W),
      .SKID          (SKID),
      .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (link_valid[g]),
      .in_ready (link_ready[g]),
      .in_data  (link_data[g]),
      .out_valid(link_valid[g+1]),
      .out_ready(link_ready[g+1]),
      .out_data (link_data[g+1]),
      .occ      (slot_occ_w[g])
    );
  end

  // Total occupancy is a pure sum of registered slot states.
  always_comb begin
    count_sum = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_sum = count_sum + CW'(slot_occ_w[i]);
    end
  end

  assign count = count_sum;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations driven in parallel, checked
// every cycle against a queue-per-slot reference plus hand-computed points.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int ND = 3;
  localparam int STG [ND] = '{2, 1, 3};
  localparam int SKD [ND] = '{0, 1, 1};
  localparam int CLR [ND] = '{1, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] in_data;

  pipe_stage_reg_if #(.DATA_W(DW)) up0 ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn0 ();
  pipe_stage_reg_if #(.DATA_W(DW)) up1 ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn1 ();
  pipe_stage_reg_if #(.DATA_W(DW)) up2 ();
  pipe_stage_reg_if #(.DATA_W(DW)) dn2 ();

  logic [$clog2(2*STG[0]+1)-1:0] cnt0;
  logic [$clog2(2*STG[1]+1)-1:0] cnt1;
  logic [$clog2(2*STG[2]+1)-1:0] cnt2;

  assign up0.valid = in_valid; assign up0.data = in_data; assign dn0.ready = out_ready;
  assign up1.valid = in_valid; assign up1.data = in_data; assign dn1.ready = out_ready;
  assign up2.valid = in_valid; assign up2.data = in_data; assign dn2.ready = out_ready;

  pipe_stage_reg #(.DATA_W(DW), .STAGES(STG[0]), .SKID(SKD[0]), .CLEAR_ON_FLUSH(CLR[0])) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up0), .dn(dn0), .count(cnt0));
  pipe_stage_reg #(.DATA_W(DW), .STAGES(STG[1]), .SKID(SKD[1]), .CLEAR_ON_FLUSH(CLR[1])) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up1), .dn(dn1), .count(cnt1));
  pipe_stage_reg #(.DATA_W(DW), .STAGES(STG[2]), .SKID(SKD[2]), .CLEAR_ON_FLUSH(CLR[2])) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .up(up2), .dn(dn2), .count(cnt2));

  logic          ov [ND];
  logic          ir [ND];
  logic [DW-1:0] od [ND];
  logic [7:0]    cn [ND];

  assign ov[0] = dn0.valid; assign ir[0] = up0.ready; assign od[0] = dn0.data; assign cn[0] = 8'(cnt0);
  assign ov[1] = dn1.valid; assign ir[1] = up1.ready; assign od[1] = dn1.data; assign cn[1] = 8'(cnt1);
  assign ov[2] = dn2.valid; assign ir[2] = up2.ready; assign od[2] = dn2.data; assign cn[2] = 8'(cnt2);

  int checks = 0;
  int errors = 0;

  // Reference: each slot is a small FIFO of capacity 1 or 2.
  logic [DW-1:0] mq [ND][4][2];
  int            ms [ND][4];
  bit            model_ok = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Can slot i of configuration d take an entry now (i == STG means downstream).
  function automatic bit m_ready(input int d, input int i);
    bit r;
    r = out_ready;
    for (int k = STG[d] - 1; k >= i; k--) begin
      if (SKD[d] != 0) r = (ms[d][k] < 2);
      else             r = (ms[d][k] == 0) || r;
    end
    return r;
  endfunction

  task automatic model_step();
    bit            fire [5];
    logic [DW-1:0] val  [5];
    int            n;
    for (int d = 0; d < ND; d++) begin
      n = STG[d];
      if (!rst_n || flush) begin
        if (!rst_n) model_ok = 1'b1;
        for (int k = 0; k < 4; k++) ms[d][k] = 0;
      end else begin
        for (int i = 0; i <= n; i++) begin
          if (i == 0) begin
            fire[i] = in_valid && m_ready(d, 0);
            val[i]  = in_data;
          end else begin
            fire[i] = (ms[d][i-1] > 0) && m_ready(d, i);
            val[i]  = mq[d][i-1][0];
          end
        end
        for (int i = 0; i < n; i++) begin
          if (fire[i+1]) begin
            mq[d][i][0] = mq[d][i][1];
            ms[d][i]--;
          end
          if (fire[i]) begin
            mq[d][i][ms[d][i]] = val[i];
            ms[d][i]++;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    int last;
    int sum;
    for (int d = 0; d < ND; d++) begin
      last = STG[d] - 1;
      sum  = 0;
      for (int k = 0; k < STG[d]; k++) sum += ms[d][k];
      chk($sformatf("d%0d out_valid", d), int'(ov[d]), (ms[d][last] > 0) ? 1 : 0);
      if (ms[d][last] > 0)
        chk($sformatf("d%0d out_data", d), int'(od[d]), int'(mq[d][last][0]));
      chk($sformatf("d%0d count", d), int'(cn[d]), sum);
      chk($sformatf("d%0d in_ready", d), int'(ir[d]), int'(m_ready(d, 0)));
      chk($sformatf("d%0d count_bound", d), (int'(cn[d]) <= 2 * STG[d]) ? 1 : 0, 1);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) compare_all();
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0055;
    out_ready = 1'b1;

    // Reset held two cycles with traffic offered.
    tick();
    tick();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst d%0d out_valid", d), int'(ov[d]), 0);
      chk($sformatf("rst d%0d count", d), int'(cn[d]), 0);
      chk($sformatf("rst d%0d out_data", d), int'(od[d]), 0);
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) chk($sformatf("post-rst d%0d in_ready", d), int'(ir[d]), 1);
    tick();

    // Streaming 0x10..0x1F: two-stage chain shows first entry after two edges, no gaps.
    out_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      in_valid = (k < 16);
      in_data  = DW'(16'h10 + k);
      tick();
      if (k == 0) begin
        chk("stream d0 first out_valid", int'(ov[0]), 0);
      end else begin
        chk("stream d0 out_valid", int'(ov[0]), 1);
        chk("stream d0 out_data", int'(od[0]), 16'h10 + k - 1);
      end
    end
    in_valid = 1'b0;
    repeat (5) tick();

    // Stall on the single skid slot: two entries fill it and drop in_ready.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    tick();
    in_data = 16'h000B;
    tick();
    in_valid = 1'b0;
    chk("stall d1 count", int'(cn[1]), 2);
    chk("stall d1 in_ready", int'(ir[1]), 0);
    chk("stall d1 out_data", int'(od[1]), 16'h000A);
    tick();
    chk("stall d1 held out_data", int'(od[1]), 16'h000A);
    out_ready = 1'b1;
    #1;
    chk("stall d1 in_ready registered", int'(ir[1]), 0);
    tick();
    chk("pop d1 out_data", int'(od[1]), 16'h000B);
    chk("pop d1 in_ready", int'(ir[1]), 1);
    chk("pop d1 count", int'(cn[1]), 1);
    tick();
    chk("drain d1 out_valid", int'(ov[1]), 0);
    repeat (4) tick();

    // Flush with a coincident offered 0xDEAD while two entries are live.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h000A;
    tick();
    in_data = 16'h000B;
    tick();
    chk("preflush d0 count", int'(cn[0]), 2);
    chk("preflush d1 count", int'(cn[1]), 2);
    in_data = 16'hDEAD;
    flush   = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("flush d%0d count", d), int'(cn[d]), 0);
      chk($sformatf("flush d%0d out_valid", d), int'(ov[d]), 0);
    end
    chk("flush d0 out_data", int'(od[0]), 0);
    chk("flush d1 out_data", int'(od[1]), 0);
    out_ready = 1'b1;
    repeat (3) tick();
    for (int d = 0; d < ND; d++) chk($sformatf("postflush d%0d out_valid", d), int'(ov[d]), 0);

    // Reset mid-stream with three live entries, coincident with flush.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = DW'(16'h31 + k);
      tick();
    end
    in_valid = 1'b0;
    chk("prereset d2 count", int'(cn[2]), 3);
    chk("prereset d2 out_data", int'(od[2]), 16'h0031);
    rst_n    = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0077;
    tick();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("midrst d%0d count", d), int'(cn[d]), 0);
      chk($sformatf("midrst d%0d out_valid", d), int'(ov[d]), 0);
      chk($sformatf("midrst d%0d out_data", d), int'(od[d]), 0);
    end
    rst_n    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Random traffic: a stall-heavy half then a mostly-flowing half.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = (c < 5000) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
      in_data   = DW'($urandom);
      flush     = ($urandom_range(0, 199) == 0);
      rst_n     = !($urandom_range(0, 999) == 0);
      tick();
    end
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    for (int d = 0; d < ND; d++) chk($sformatf("final d%0d count", d), int'(cn[d]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
